// File: rtl/inst_prefetch_buffer_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
package inst_prefetch_buffer_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned FIFO_DEPTH = 4;

  localparam logic [XLEN-1:0] RESET_PC    = 32'h0000_0000;
  localparam logic [XLEN-1:0] INST_STRIDE = 32'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] opcode;
    logic [XLEN-1:0] next_addr;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fifo.sv
// Circular buffer of fetched {opcode, next-address} entries with flush.
module inst_fifo
  import inst_prefetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  fetch_entry_t             din_i,
  input  logic                     pop_i,
  output fetch_entry_t             dout_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic             full_c;
  logic             empty_c;
  logic             push_ok_c;
  logic             pop_ok_c;

  // Extra pointer bit separates full from empty when the indices match.
  assign full_c    = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                     (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign empty_c   = (wr_ptr_q == rd_ptr_q);
  assign push_ok_c = push_i & ~full_c & ~flush_i;
  assign pop_ok_c  = pop_i & ~empty_c & ~flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok_c) begin
        mem_q[wr_ptr_q[IDX_W-1:0]] <= din_i;
        wr_ptr_q                   <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  assign dout_o  = mem_q[rd_ptr_q[IDX_W-1:0]];
  assign count_o = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/inst_prefetch_buffer.sv
// Sequential instruction prefetcher: single-outstanding bus fetch into a FIFO,
// with redirect flushing queued entries and dropping any in-flight response.
module inst_prefetch_buffer
  import inst_prefetch_buffer_pkg::*;
#(
  parameter int unsigned     DEPTH      = FIFO_DEPTH,
  parameter logic [XLEN-1:0] RESET_ADDR = RESET_PC
) (
  input  logic                   CLK,
  input  logic                   Reset,
  input  logic                   redirect,
  input  logic [XLEN-1:0]        redirectAddress,
  output logic                   memReq,
  output logic [XLEN-1:0]        memAddress,
  input  logic                   memAck,
  input  logic [XLEN-1:0]        memData,
  output logic                   instValid,
  output logic [XLEN-1:0]        instOpCode,
  output logic [XLEN-1:0]        instNextAddress,
  input  logic                   instTake,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
  localparam int unsigned CNTX_W = CNT_W + 1;
  localparam logic [CNTX_W-1:0] DEPTH_X = CNTX_W'(DEPTH);

  fetch_state_e     state_q, state_d;
  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  redir_pc_q, redir_pc_d;
  logic             mem_req_q;
  logic [XLEN-1:0]  pc_inc_c;
  logic             push_c;
  logic             pop_c;
  logic [CNT_W-1:0] fifo_count;
  logic [CNTX_W-1:0] cnt_after_pop_c;
  logic [CNTX_W-1:0] cnt_after_push_c;
  fetch_entry_t     entry_c;
  fetch_entry_t     head;

  assign pc_inc_c         = fetch_pc_q + INST_STRIDE;
  assign pop_c            = instTake & instValid & ~redirect;
  assign cnt_after_pop_c  = {1'b0, fifo_count} - CNTX_W'(pop_c);
  assign cnt_after_push_c = cnt_after_pop_c + CNTX_W'(1);
  assign entry_c          = '{opcode: memData, next_addr: pc_inc_c};

  // Next-state: a request is only launched when its entry already has room.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    redir_pc_d = redir_pc_q;
    push_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (redirect) begin
          fetch_pc_d = redirectAddress;
        end else if (cnt_after_pop_c < DEPTH_X) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (memAck) begin
          if (redirect) begin
            fetch_pc_d = redirectAddress;
            state_d    = IDLE;
          end else begin
            push_c     = 1'b1;
            fetch_pc_d = pc_inc_c;
            if (cnt_after_push_c >= DEPTH_X) begin
              state_d = IDLE;
            end
          end
        end else if (redirect) begin
          redir_pc_d = redirectAddress;
          state_d    = DROP;
        end
      end
      DROP: begin
        if (redirect) begin
          redir_pc_d = redirectAddress;
        end
        if (memAck) begin
          fetch_pc_d = redirect ? redirectAddress : redir_pc_q;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_ADDR;
      redir_pc_q <= RESET_ADDR;
      mem_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      redir_pc_q <= redir_pc_d;
      mem_req_q  <= (state_d != IDLE);
    end
  end

  inst_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (Reset),
    .flush_i (redirect),
    .push_i  (push_c),
    .din_i   (entry_c),
    .pop_i   (pop_c),
    .dout_o  (head),
    .count_o (fifo_count)
  );

  assign memReq          = mem_req_q;
  assign memAddress      = fetch_pc_q;
  assign instValid       = (fifo_count != '0);
  assign instOpCode      = head.opcode;
  assign instNextAddress = head.next_addr;
  assign count           = fifo_count;

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Directed vector bench for inst_prefetch_buffer (DEPTH=4, RESET_ADDR=0).
module tb_inst_prefetch_buffer;

  logic        CLK;
  logic        Reset;
  logic        redirect;
  logic [31:0] redirectAddress;
  logic        memReq;
  logic [31:0] memAddress;
  logic        memAck;
  logic [31:0] memData;
  logic        instValid;
  logic [31:0] instOpCode;
  logic [31:0] instNextAddress;
  logic        instTake;
  logic [2:0]  count;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [31:0] BAD = 32'hBAD0_0BAD;

  typedef struct {
    logic        ack;
    logic [31:0] data;
    logic        take;
    logic        redir;
    logic [31:0] raddr;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_op;
    logic [31:0] exp_next;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  inst_prefetch_buffer #(
    .DEPTH(4),
    .RESET_ADDR(32'h0000_0000)
  ) dut (
    .CLK             (CLK),
    .Reset           (Reset),
    .redirect        (redirect),
    .redirectAddress (redirectAddress),
    .memReq          (memReq),
    .memAddress      (memAddress),
    .memAck          (memAck),
    .memData         (memData),
    .instValid       (instValid),
    .instOpCode      (instOpCode),
    .instNextAddress (instNextAddress),
    .instTake        (instTake),
    .count           (count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory image: each word is a recognisable function of its address.
  function automatic logic [31:0] opc(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  function automatic vec_t mk(input logic ack, input logic [31:0] data,
                              input logic take, input logic redir,
                              input logic [31:0] raddr, input logic req,
                              input logic [31:0] addr, input logic valid,
                              input logic [31:0] op, input logic [31:0] nxt,
                              input logic [31:0] cnt);
    vec_t v;
    v.ack = ack; v.data = data; v.take = take; v.redir = redir; v.raddr = raddr;
    v.exp_req = req; v.exp_addr = addr; v.exp_valid = valid;
    v.exp_op = op; v.exp_next = nxt; v.exp_cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  // Apply inputs for one cycle, then check the registered outputs after the edge.
  task automatic run(input string tag, input vec_t v);
    memAck          = v.ack;
    memData         = v.data;
    instTake        = v.take;
    redirect        = v.redir;
    redirectAddress = v.raddr;
    @(posedge CLK);
    #1;
    chk({tag, ".memReq"},     32'(memReq),    32'(v.exp_req));
    chk({tag, ".memAddress"}, memAddress,     v.exp_addr);
    chk({tag, ".instValid"},  32'(instValid), 32'(v.exp_valid));
    chk({tag, ".count"},      32'(count),     v.exp_cnt);
    if (v.exp_valid) begin
      chk({tag, ".instOpCode"},      instOpCode,      v.exp_op);
      chk({tag, ".instNextAddress"}, instNextAddress, v.exp_next);
    end
  endtask

  initial begin
    Reset = 1'b1; redirect = 1'b0; redirectAddress = '0;
    memAck = 1'b0; memData = '0; instTake = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst.memReq",          32'(memReq),    32'd0);
    chk("rst.memAddress",      memAddress,     32'h0);
    chk("rst.instValid",       32'(instValid), 32'd0);
    chk("rst.instOpCode",      instOpCode,     32'h0);
    chk("rst.instNextAddress", instNextAddress, 32'h0);
    chk("rst.count",           32'(count),     32'd0);
    Reset = 1'b0;

    // Fill from reset with zero-wait memory, then single pops against a full FIFO.
    //             ack data          tk rd raddr  req addr     vld op            next     cnt
    vecs.push_back(mk(0, 32'h0,      1, 0, 32'h0, 1, 32'h00,   0, 32'h0,         32'h0,   0));
    vecs.push_back(mk(1, opc(32'h0), 0, 0, 32'h0, 1, 32'h04,   1, opc(32'h0),    32'h04,  1));
    vecs.push_back(mk(1, opc(32'h4), 0, 0, 32'h0, 1, 32'h08,   1, opc(32'h0),    32'h04,  2));
    vecs.push_back(mk(1, opc(32'h8), 0, 0, 32'h0, 1, 32'h0C,   1, opc(32'h0),    32'h04,  3));
    vecs.push_back(mk(1, opc(32'hC), 0, 0, 32'h0, 0, 32'h10,   1, opc(32'h0),    32'h04,  4));
    vecs.push_back(mk(1, BAD,        0, 0, 32'h0, 0, 32'h10,   1, opc(32'h0),    32'h04,  4));
    vecs.push_back(mk(1, BAD,        1, 0, 32'h0, 1, 32'h10,   1, opc(32'h4),    32'h08,  3));
    vecs.push_back(mk(1, opc(32'h10),0, 0, 32'h0, 0, 32'h14,   1, opc(32'h4),    32'h08,  4));
    vecs.push_back(mk(1, BAD,        0, 0, 32'h0, 0, 32'h14,   1, opc(32'h4),    32'h08,  4));
    vecs.push_back(mk(1, BAD,        1, 0, 32'h0, 1, 32'h14,   1, opc(32'h8),    32'h0C,  3));
    vecs.push_back(mk(1, opc(32'h14),1, 0, 32'h0, 1, 32'h18,   1, opc(32'hC),    32'h10,  3));
    vecs.push_back(mk(0, BAD,        1, 0, 32'h0, 1, 32'h18,   1, opc(32'h10),   32'h14,  2));
    vecs.push_back(mk(1, opc(32'h18),0, 0, 32'h0, 1, 32'h1C,   1, opc(32'h10),   32'h14,  3));
    for (int i = 0; i < vecs.size(); i++) begin
      run($sformatf("v%0d", i), vecs[i]);
    end

    // Redirect during the second of three wait states: old address held, data dropped.
    run("wait1", mk(0, BAD, 0, 0, 32'h0,   1, 32'h1C,  1, opc(32'h10), 32'h14, 3));
    run("wait2", mk(0, BAD, 0, 1, 32'h200, 1, 32'h1C,  0, 32'h0, 32'h0, 0));
    run("wait3", mk(0, BAD, 0, 0, 32'h0,   1, 32'h1C,  0, 32'h0, 32'h0, 0));
    run("drop",  mk(1, BAD, 0, 0, 32'h0,   0, 32'h200, 0, 32'h0, 32'h0, 0));
    run("rq200", mk(0, BAD, 0, 0, 32'h0,   1, 32'h200, 0, 32'h0, 32'h0, 0));
    run("ak200", mk(1, opc(32'h200), 0, 0, 32'h0, 1, 32'h204, 1, opc(32'h200), 32'h204, 1));

    // Redirect, take and ack in one cycle: redirect wins, ack data discarded.
    run("rta",   mk(1, BAD, 1, 1, 32'h80,  0, 32'h80,  0, 32'h0, 32'h0, 0));
    run("rq80",  mk(0, BAD, 0, 0, 32'h0,   1, 32'h80,  0, 32'h0, 32'h0, 0));
    run("ak80",  mk(1, opc(32'h80), 0, 0, 32'h0, 1, 32'h84, 1, opc(32'h80), 32'h84, 1));

    // Address wrap at the top of the 32-bit space.
    run("rwrap", mk(1, BAD, 0, 1, 32'hFFFF_FFF8, 0, 32'hFFFF_FFF8, 0, 32'h0, 32'h0, 0));
    run("rqF8",  mk(0, BAD, 0, 0, 32'h0, 1, 32'hFFFF_FFF8, 0, 32'h0, 32'h0, 0));
    run("akF8",  mk(1, opc(32'hFFFF_FFF8), 0, 0, 32'h0, 1, 32'hFFFF_FFFC, 1,
                    opc(32'hFFFF_FFF8), 32'hFFFF_FFFC, 1));
    run("akFC",  mk(1, opc(32'hFFFF_FFFC), 1, 0, 32'h0, 1, 32'h0, 1,
                    opc(32'hFFFF_FFFC), 32'h0, 1));
    run("ak00",  mk(1, opc(32'h0), 0, 0, 32'h0, 1, 32'h4, 1,
                    opc(32'hFFFF_FFFC), 32'h0, 2));

    // Asynchronous reset mid-request with two entries queued.
    memAck = 1'b0; instTake = 1'b0; redirect = 1'b0;
    Reset = 1'b1;
    #2;
    chk("arst.memReq",     32'(memReq),    32'd0);
    chk("arst.instValid",  32'(instValid), 32'd0);
    chk("arst.count",      32'(count),     32'd0);
    chk("arst.memAddress", memAddress,     32'h0);
    @(posedge CLK);
    #1;
    Reset = 1'b0;
    run("rs0",   mk(0, BAD, 0, 0, 32'h0,  1, 32'h0,  0, 32'h0, 32'h0, 0));
    run("rs1",   mk(1, opc(32'h0), 0, 0, 32'h0, 1, 32'h4, 1, opc(32'h0), 32'h4, 1));
    // Redirect while waiting, then a second redirect in DROP replaces the target.
    run("dr1",   mk(0, BAD, 0, 1, 32'h300, 1, 32'h4,   0, 32'h0, 32'h0, 0));
    run("dr2",   mk(0, BAD, 0, 1, 32'h340, 1, 32'h4,   0, 32'h0, 32'h0, 0));
    run("dr3",   mk(1, BAD, 0, 0, 32'h0,   0, 32'h340, 0, 32'h0, 32'h0, 0));
    run("dr4",   mk(0, BAD, 0, 0, 32'h0,   1, 32'h340, 0, 32'h0, 32'h0, 0));
    run("dr5",   mk(1, opc(32'h340), 0, 0, 32'h0, 1, 32'h344, 1, opc(32'h340), 32'h344, 1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
